// File: rtl/sample_ring_ctrl.sv
// Circular sample history in a single-port SRAM, with oldest-first window readback.
// A 4-entry output FIFO absorbs the SRAM's registered-read latency under backpressure.
//
// state | meaning
// IDLE  | accepting samples; a window request may start a transfer
// READ  | streaming the requested window; sample writes are held off
module sample_ring_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int OFIFO_D = 4
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              win_start,
    input  logic [ADDR_W:0]   win_len,
    output logic              win_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [ADDR_W:0]   count,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    localparam int PW = $clog2(OFIFO_D);
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [PW+1:0] OCC_MAX = (PW+2)'(OFIFO_D);

    typedef enum logic {IDLE, READ} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt, rd_ptr;
    logic [ADDR_W:0]   count_nxt, remaining, eff;
    logic              do_write, do_read, win_go;
    logic              rd_pend, rd_pend_last;

    logic [DATA_W-1:0] fifo_data [OFIFO_D];
    logic              fifo_last [OFIFO_D];
    logic [PW-1:0]     fifo_wp, fifo_rp;
    logic [PW:0]       fifo_cnt;
    logic [PW+1:0]     occ;
    logic              push, pop;

    assign in_ready  = (state == IDLE);
    assign win_busy  = (state == READ);
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = fifo_data[fifo_rp];
    assign out_last  = out_valid & fifo_last[fifo_rp];
    assign push      = rd_pend;
    assign pop       = out_valid & out_ready;

    always_comb begin
        do_write   = (state == IDLE) & in_valid;
        count_nxt  = (do_write && count != FULL) ? count + ONE : count;
        wr_ptr_nxt = do_write ? wr_ptr + 1'b1 : wr_ptr;
        // window length counts a sample being written in the same cycle
        eff        = (win_len < count_nxt) ? win_len : count_nxt;
        win_go     = (state == IDLE) & win_start & (eff != '0);
        // an outstanding read already owns one FIFO slot
        occ        = {1'b0, fifo_cnt} + {{(PW+1){1'b0}}, rd_pend};
        do_read    = (state == READ) & (remaining != '0) & (occ < OCC_MAX);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (win_go) state_nxt = READ;
            READ: if (pop && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sram_cs = 1'b0;
        sram_we = 1'b0;
        sram_a  = '0;
        sram_d  = '0;
        if (do_write) begin
            sram_cs = 1'b1;
            sram_we = 1'b1;
            sram_a  = wr_ptr;
            sram_d  = in_data;
        end else if (do_read) begin
            sram_cs = 1'b1;
            sram_a  = rd_ptr;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            remaining    <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_ptr       <= wr_ptr_nxt;
            count        <= count_nxt;
            rd_pend      <= do_read;
            rd_pend_last <= do_read & (remaining == ONE);
            if (win_go) begin
                rd_ptr    <= wr_ptr_nxt - eff[ADDR_W-1:0];
                remaining <= eff;
            end else if (do_read) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - ONE;
            end
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < OFIFO_D; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[fifo_wp] <= sram_q;
                fifo_last[fifo_wp] <= rd_pend_last;
                fifo_wp            <= fifo_wp + 1'b1;
            end
            if (pop) fifo_rp <= fifo_rp + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_ring_ctrl.sv
// Directed bench for sample_ring_ctrl with a behavioural 1-cycle-latency SRAM.
// A per-cycle vector table covers the basic window; hand-written sequences cover the rest.
module tb_sample_ring_ctrl;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        win_start = 1'b0;
    logic [8:0]  win_len = '0;
    logic        win_busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic [8:0]  count;
    logic        sram_cs, sram_we;
    logic [7:0]  sram_a;
    logic [15:0] sram_d;
    logic [15:0] sram_q = '0;
    logic [15:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    sample_ring_ctrl dut (
        .CK(CK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .win_start(win_start), .win_len(win_len), .win_busy(win_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .count(count),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 CK = ~CK;

    always @(posedge CK) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_a] <= sram_d;
            else         sram_q <= mem[sram_a];
        end
    end

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        ws;
        logic [8:0]  wl;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [15:0] e_od;
        logic        e_ol;
        logic        e_busy;
        logic [8:0]  e_cnt;
        logic        e_cs;
        logic        e_we;
    } vec_t;

    vec_t vt [12];
    bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        win_start = 1'b0;
        out_ready = 1'b0;
        RST       = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic write_samples(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 16'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic start_win(input logic [8:0] len);
        win_start = 1'b1;
        win_len   = len;
        tick();
        win_start = 1'b0;
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk({name, " busy"}, win_busy, 0);
            chk({name, " cs"}, sram_cs, 0);
            tick();
        end
    endtask

    // Expects n beats of consecutive values starting at base; optionally stalls
    // the consumer and holds in_valid high during the transfer.
    task automatic collect(input string name, input int n, input logic [15:0] base,
                           input bit stall, input bit hold, input logic [8:0] cnt_exp);
        int   k = 0;
        int   reads = 0;
        int   pops = 0;
        bit   done = 0;
        bit   prev_stall = 0;
        logic [15:0] prev_data = '0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            out_ready = stall ? pat[cyc % 6] : 1'b1;
            in_valid  = hold & win_busy;
            in_data   = 16'hdead;
            #1;
            if (hold && win_busy) begin
                chk({name, " in_ready"}, in_ready, 0);
                chk({name, " no write"}, sram_we, 0);
                chk({name, " count held"}, count, cnt_exp);
            end
            if (prev_stall) begin
                chk({name, " stall valid"}, out_valid, 1);
                chk({name, " stall data"}, out_data, prev_data);
            end
            if (sram_cs && !sram_we) begin
                reads++;
                chk({name, " occupancy"}, (reads - pops) <= 4, 1);
            end
            if (out_valid && out_ready) begin
                chk({name, " data"}, out_data, base + 16'(k));
                chk({name, " last"}, out_last, (k == n - 1));
                pops++;
                k++;
                if (out_last) done = 1;
            end
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk({name, " beats"}, k, n);
        chk({name, " busy end"}, win_busy, 0);
        chk({name, " ready end"}, in_ready, 1);
        chk({name, " valid end"}, out_valid, 0);
    endtask

    initial begin
        int beats;
        vt[0]  = '{1'b1, 16'h0010, 1'b0, 9'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'd0, 1'b1, 1'b1};
        vt[1]  = '{1'b1, 16'h0011, 1'b0, 9'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'd1, 1'b1, 1'b1};
        vt[2]  = '{1'b1, 16'h0012, 1'b0, 9'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'd2, 1'b1, 1'b1};
        vt[3]  = '{1'b1, 16'h0013, 1'b0, 9'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'd3, 1'b1, 1'b1};
        vt[4]  = '{1'b1, 16'h0014, 1'b0, 9'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'd4, 1'b1, 1'b1};
        vt[5]  = '{1'b0, 16'h0000, 1'b1, 9'd3, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'd5, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 16'h0000, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 9'd5, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 16'h0000, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 9'd5, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 16'h0000, 1'b0, 9'd0, 1'b1, 1'b0, 1'b1, 16'h0012, 1'b0, 1'b1, 9'd5, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 16'h0000, 1'b0, 9'd0, 1'b1, 1'b0, 1'b1, 16'h0013, 1'b0, 1'b1, 9'd5, 1'b0, 1'b0};
        vt[10] = '{1'b0, 16'h0000, 1'b0, 9'd0, 1'b1, 1'b0, 1'b1, 16'h0014, 1'b1, 1'b1, 9'd5, 1'b0, 1'b0};
        vt[11] = '{1'b0, 16'h0000, 1'b0, 9'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'd5, 1'b0, 1'b0};

        // reset values
        RST = 1'b1;
        #12;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst out_data", out_data, 0);
        chk("rst win_busy", win_busy, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst count", count, 0);

        // basic window, cycle by cycle
        do_reset();
        for (int i = 0; i < 12; i++) begin
            in_valid  = vt[i].iv;
            in_data   = vt[i].id;
            win_start = vt[i].ws;
            win_len   = vt[i].wl;
            out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), in_ready, vt[i].e_irdy);
            chk($sformatf("v%0d out_valid", i), out_valid, vt[i].e_ov);
            if (vt[i].e_ov) chk($sformatf("v%0d out_data", i), out_data, vt[i].e_od);
            chk($sformatf("v%0d out_last", i), out_last, vt[i].e_ol);
            chk($sformatf("v%0d win_busy", i), win_busy, vt[i].e_busy);
            chk($sformatf("v%0d count", i), count, vt[i].e_cnt);
            chk($sformatf("v%0d sram_cs", i), sram_cs, vt[i].e_cs);
            chk($sformatf("v%0d sram_we", i), sram_we, vt[i].e_we);
            tick();
        end
        in_valid  = 1'b0;
        win_start = 1'b0;

        // wrap-around, full-depth window
        do_reset();
        write_samples(16'd0, 300);
        #1;
        chk("wrap count", count, 256);
        start_win(9'd256);
        collect("wrap", 256, 16'd44, 1'b0, 1'b0, 9'd0);

        // clamp to count, ignore empty windows
        do_reset();
        write_samples(16'h0021, 2);
        start_win(9'd5);
        collect("clamp", 2, 16'h0021, 1'b0, 1'b0, 9'd0);
        start_win(9'd0);
        check_idle("len0", 4);
        do_reset();
        start_win(9'd3);
        check_idle("cnt0", 4);

        // backpressure with writes attempted during READ
        do_reset();
        write_samples(16'h0040, 8);
        start_win(9'd8);
        collect("bp", 8, 16'h0040, 1'b1, 1'b1, 9'd8);
        #1;
        chk("bp count after", count, 8);

        // write and window request in the same cycle
        in_valid  = 1'b1;
        in_data   = 16'h00aa;
        win_start = 1'b1;
        win_len   = 9'd1;
        #1;
        chk("same-cycle we", sram_we, 1);
        tick();
        in_valid  = 1'b0;
        win_start = 1'b0;
        collect("same-cycle", 1, 16'h00aa, 1'b0, 1'b0, 9'd0);
        chk("same-cycle count", count, 9);

        // reset in the middle of a window
        do_reset();
        write_samples(16'h0060, 6);
        start_win(9'd6);
        out_ready = 1'b1;
        beats = 0;
        for (int cyc = 0; cyc < 20 && beats < 2; cyc++) begin
            #1;
            if (out_valid && out_ready) begin
                chk("midrst data", out_data, 16'h0060 + 16'(beats));
                beats++;
            end
            tick();
        end
        chk("midrst beats", beats, 2);
        RST = 1'b1;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst win_busy", win_busy, 0);
        chk("midrst count", count, 0);
        chk("midrst in_ready", in_ready, 1);
        out_ready = 1'b0;
        tick();
        RST = 1'b0;
        start_win(9'd4);
        check_idle("postrst", 4);
        write_samples(16'h0077, 1);
        start_win(9'd4);
        collect("postrst win", 1, 16'h0077, 1'b0, 1'b0, 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
